// File: rtl/i2c_slave_regs_if.sv
// rtl/i2c_slave_regs_if.sv - host-side register read port and bus-write notification bundle
interface i2c_slave_regs_if #(
  parameter int PW = 4
);
  logic [PW-1:0] host_addr;
  logic [7:0]    host_rdata;
  logic          wr_valid;
  logic [PW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          busy;

  modport slave (
    input  host_addr,
    output host_rdata, wr_valid, wr_addr, wr_data, busy
  );

  modport master (
    output host_addr,
    input  host_rdata, wr_valid, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/i2c_slave_regs.sv
// rtl/i2c_slave_regs.sv - I2C target with pointer-addressed register file
// SCL/SDA are oversampled on clk; SDA is only ever pulled low or released.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h50,
  parameter int         DEPTH      = 16,
  localparam int        PW         = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           scl,
  inout  wire            sda,
  i2c_slave_regs_if.slave host
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_t;

  state_t        state_q, state_d;
  logic          scl_s1_q, scl_s1_d, scl_s2_q, scl_s2_d, scl_h_q, scl_h_d;
  logic          sda_s1_q, sda_s1_d, sda_s2_q, sda_s2_d, sda_h_q, sda_h_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    sr_q, sr_d;
  logic          phase_q, phase_d;
  logic          rw_q, rw_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          ptr_loaded_q, ptr_loaded_d;
  logic          sda_oe_q, sda_oe_d;
  logic          busy_q, busy_d;
  logic          pend_q, pend_d;
  logic          wr_valid_q, wr_valid_d;
  logic [PW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [7:0]    host_rdata_q, host_rdata_d;
  logic [7:0]    regs_q [DEPTH];
  logic [7:0]    regs_d [DEPTH];

  logic       scl_rise, scl_fall, start_det, stop_det, last_bit;
  logic [7:0] byte_in;

  // START/STOP require SCL high on both samples so an SCL edge never masquerades as one
  assign scl_rise  = scl_s2_q & ~scl_h_q;
  assign scl_fall  = ~scl_s2_q & scl_h_q;
  assign start_det = scl_s2_q & scl_h_q & sda_h_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_h_q & ~sda_h_q & sda_s2_q;
  assign byte_in   = {sr_q[6:0], sda_s2_q};
  assign last_bit  = scl_rise && (cnt_q == 3'd7);

  assign sda             = sda_oe_q ? 1'b0 : 1'bz;
  assign host.host_rdata = host_rdata_q;
  assign host.wr_valid   = wr_valid_q;
  assign host.wr_addr    = wr_addr_q;
  assign host.wr_data    = wr_data_q;
  assign host.busy       = busy_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (start_det) begin
      state_d = ADDR;
    end else if (stop_det) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:      state_d = IDLE;
        ADDR:      if (last_bit) state_d = (byte_in[7:1] == SLAVE_ADDR) ? ADDR_ACK : IDLE;
        ADDR_ACK:  if (scl_fall && phase_q) state_d = rw_q ? RDATA : (ptr_loaded_q ? WDATA : PTR);
        PTR:       if (last_bit) state_d = PTR_ACK;
        PTR_ACK:   if (scl_fall && phase_q) state_d = WDATA;
        WDATA:     if (last_bit) state_d = WDATA_ACK;
        WDATA_ACK: if (scl_fall && phase_q) state_d = WDATA;
        RDATA:     if (last_bit) state_d = RDATA_ACK;
        RDATA_ACK: begin
          if (scl_rise && sda_s2_q)      state_d = IDLE;
          else if (scl_fall && phase_q)  state_d = RDATA;
        end
        default:   state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    scl_s1_d     = scl;
    scl_s2_d     = scl_s1_q;
    scl_h_d      = scl_s2_q;
    sda_s1_d     = sda;
    sda_s2_d     = sda_s1_q;
    sda_h_d      = sda_s2_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    phase_d      = phase_q;
    rw_d         = rw_q;
    ptr_d        = ptr_q;
    ptr_loaded_d = ptr_loaded_q;
    sda_oe_d     = sda_oe_q;
    busy_d       = busy_q;
    pend_d       = 1'b0;
    wr_valid_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    regs_d       = regs_q;
    host_rdata_d = regs_q[host.host_addr];

    // Commit a received byte one cycle after its last bit; the pointer is stable until the ACK ends
    if (pend_q) begin
      regs_d[ptr_q] = sr_q;
      wr_valid_d    = 1'b1;
      wr_addr_d     = ptr_q;
      wr_data_d     = sr_q;
    end

    if (start_det || stop_det) begin
      sda_oe_d = 1'b0;
      cnt_d    = 3'd0;
      phase_d  = 1'b0;
      if (stop_det) begin
        busy_d       = 1'b0;
        ptr_loaded_d = 1'b0;
      end
    end else begin
      case (state_q)
        ADDR, PTR, WDATA: begin
          if (scl_rise) begin
            sr_d  = byte_in;
            cnt_d = cnt_q + 3'd1;
          end
          if (last_bit) begin
            phase_d = 1'b0;
            if (state_q == ADDR) begin
              rw_d   = byte_in[0];
              busy_d = (byte_in[7:1] == SLAVE_ADDR);
            end else if (state_q == PTR) begin
              ptr_d        = byte_in[PW-1:0];
              ptr_loaded_d = 1'b1;
            end else begin
              pend_d = 1'b1;
            end
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          // First falling edge opens the ACK slot, the second one closes it
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              if (state_q == WDATA_ACK) ptr_d = ptr_q + PW'(1);
              if (state_q == ADDR_ACK && rw_q) begin
                sr_d     = {regs_q[ptr_q][6:0], 1'b0};
                sda_oe_d = ~regs_q[ptr_q][7];
              end
            end
          end
        end
        RDATA: begin
          if (scl_rise) cnt_d = cnt_q + 3'd1;
          if (scl_fall) begin
            sda_oe_d = ~sr_q[7];
            sr_d     = {sr_q[6:0], 1'b0};
          end
          if (last_bit) phase_d = 1'b0;
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            ptr_d = ptr_q + PW'(1);
            if (!sda_s2_q) phase_d = 1'b1;
          end
          if (scl_fall) begin
            if (phase_q) begin
              sr_d     = {regs_q[ptr_q][6:0], 1'b0};
              sda_oe_d = ~regs_q[ptr_q][7];
              phase_d  = 1'b0;
            end else begin
              sda_oe_d = 1'b0;
            end
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1_q     <= 1'b1;
      scl_s2_q     <= 1'b1;
      scl_h_q      <= 1'b1;
      sda_s1_q     <= 1'b1;
      sda_s2_q     <= 1'b1;
      sda_h_q      <= 1'b1;
      cnt_q        <= 3'd0;
      sr_q         <= 8'h00;
      phase_q      <= 1'b0;
      rw_q         <= 1'b0;
      ptr_q        <= '0;
      ptr_loaded_q <= 1'b0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      pend_q       <= 1'b0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= 8'h00;
      host_rdata_q <= 8'h00;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= 8'h00;
    end else begin
      scl_s1_q     <= scl_s1_d;
      scl_s2_q     <= scl_s2_d;
      scl_h_q      <= scl_h_d;
      sda_s1_q     <= sda_s1_d;
      sda_s2_q     <= sda_s2_d;
      sda_h_q      <= sda_h_d;
      cnt_q        <= cnt_d;
      sr_q         <= sr_d;
      phase_q      <= phase_d;
      rw_q         <= rw_d;
      ptr_q        <= ptr_d;
      ptr_loaded_q <= ptr_loaded_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      pend_q       <= pend_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      host_rdata_q <= host_rdata_d;
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// tb/tb_i2c_slave_regs.sv - directed bench driving the I2C target as a bus master
module tb_i2c_slave_regs;
  localparam int Q = 60;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl_m = 1'b1;
  logic sda_m = 1'b1;
  wire  sda;

  pullup (sda);
  assign sda = sda_m ? 1'bz : 1'b0;

  i2c_slave_regs_if #(.PW(4)) hif ();

  i2c_slave_regs #(.SLAVE_ADDR(7'h50), .DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .scl   (scl_m),
    .sda   (sda),
    .host  (hif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int tgt_low = 0;
  int busy_hi = 0;
  logic [3:0] wv_addr [$];
  logic [7:0] wv_data [$];

  // Target is pulling SDA whenever the bus is low while the master releases it
  always @(negedge clk) begin
    if (!reset) begin
      if (sda_m && sda === 1'b0) tgt_low++;
      if (hif.busy) busy_hi++;
      if (hif.wr_valid) begin
        wv_addr.push_back(hif.wr_addr);
        wv_data.push_back(hif.wr_data);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic bus_start;
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; sda_m = 1'b0; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; #Q; scl_m = 1'b1; #Q; sda_m = 1'b1; #Q;
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; #Q; scl_m = 1'b1; #(2*Q); scl_m = 1'b0; #Q;
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; #Q; scl_m = 1'b1; #Q; b = sda; #Q; scl_m = 1'b0; #Q;
  endtask

  task automatic put_byte(input logic [7:0] d, output logic ack);
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(ack);
  endtask

  task automatic get_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(nack);
  endtask

  // Samples wr_valid 3, 4 and 5 clk after the 8th SCL rise reaches the pin
  task automatic put_byte_timed(input logic [7:0] d, output logic ack);
    logic [2:0] w;
    for (int i = 7; i >= 1; i--) put_bit(d[i]);
    sda_m = d[0]; #Q; scl_m = 1'b1;
    #30 w[0] = hif.wr_valid;
    #10 w[1] = hif.wr_valid;
    #10 w[2] = hif.wr_valid;
    #(2*Q-50); scl_m = 1'b0; #Q;
    get_bit(ack);
    chk("wr_valid_timing", 32'(w), 32'(3'b010));
  endtask

  task automatic host_read(input logic [3:0] a, input logic [7:0] exp, input string name);
    hif.host_addr = a;
    #10;
    chk(name, 32'(hif.host_rdata), 32'(exp));
  endtask

  typedef struct {
    logic [3:0] ptr;
    logic [7:0] data;
  } wvec_t;

  wvec_t tbl [5];

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic a0, a1, a2, a3;
    logic [7:0] rd0, rd1;
    int lo0;

    tbl[0] = '{4'd3,  8'h5A};
    tbl[1] = '{4'd4,  8'hC3};
    tbl[2] = '{4'd7,  8'hFF};
    tbl[3] = '{4'd10, 8'h80};
    tbl[4] = '{4'd0,  8'h01};

    hif.host_addr = 4'd0;
    #2;
    #20;
    chk("rst_busy",     32'(hif.busy),       32'(0));
    chk("rst_wr_valid", 32'(hif.wr_valid),   32'(0));
    chk("rst_sda",      32'(sda),            32'(1));
    reset = 1'b0;
    #20;
    chk("rst_wr_addr",    32'(hif.wr_addr),    32'(0));
    chk("rst_wr_data",    32'(hif.wr_data),    32'(0));
    chk("rst_host_rdata", 32'(hif.host_rdata), 32'(0));

    for (int i = 0; i < 5; i++) begin
      wv_addr.delete();
      wv_data.delete();
      bus_start;
      put_byte(8'hA0, a0);
      put_byte({4'h0, tbl[i].ptr}, a1);
      put_byte_timed(tbl[i].data, a2);
      bus_stop;
      #40;
      chk("vec_acks", 32'({a0, a1, a2}), 32'(3'b000));
      chk("vec_wv_count", 32'(wv_addr.size()), 32'(1));
      if (wv_addr.size() > 0) begin
        chk("vec_wr_addr", 32'(wv_addr[0]), 32'(tbl[i].ptr));
        chk("vec_wr_data", 32'(wv_data[0]), 32'(tbl[i].data));
      end
      host_read(tbl[i].ptr, tbl[i].data, "vec_host_rdata");
    end

    // Repeated-start read of reg 3, then a pointer-less read of reg 4
    bus_start;
    put_byte(8'hA0, a0);
    put_byte(8'h03, a1);
    bus_start;
    put_byte(8'hA1, a2);
    get_byte(rd0, 1'b1);
    chk("rs_acks", 32'({a0, a1, a2}), 32'(3'b000));
    chk("rs_rdata", 32'(rd0), 32'(8'h5A));
    chk("rs_busy_before_stop", 32'(hif.busy), 32'(1));
    bus_stop;
    #40;
    chk("rs_busy_after_stop", 32'(hif.busy), 32'(0));
    bus_start;
    put_byte(8'hA1, a0);
    get_byte(rd0, 1'b1);
    bus_stop;
    chk("ptr_read_ack", 32'(a0), 32'(0));
    chk("ptr_after_nack", 32'(rd0), 32'(8'hC3));

    // Address mismatch
    lo0 = tgt_low;
    busy_hi = 0;
    wv_addr.delete();
    bus_start;
    put_byte(8'hA2, a0);
    put_byte(8'h03, a1);
    put_byte(8'hEE, a2);
    bus_stop;
    #40;
    chk("mm_acks", 32'({a0, a1, a2}), 32'(3'b111));
    chk("mm_sda_low", 32'(tgt_low - lo0), 32'(0));
    chk("mm_busy", 32'(busy_hi), 32'(0));
    chk("mm_wv", 32'(wv_addr.size()), 32'(0));
    host_read(4'd3, 8'h5A, "mm_reg3");

    // Burst write wrapping from 15 to 0
    wv_addr.delete();
    wv_data.delete();
    bus_start;
    put_byte(8'hA0, a0);
    put_byte(8'h0F, a1);
    put_byte(8'h11, a2);
    put_byte(8'h22, a3);
    bus_stop;
    #40;
    chk("wrap_acks", 32'({a0, a1, a2, a3}), 32'(4'b0000));
    chk("wrap_wv_count", 32'(wv_addr.size()), 32'(2));
    if (wv_addr.size() == 2) begin
      chk("wrap_addr0", 32'(wv_addr[0]), 32'(15));
      chk("wrap_data0", 32'(wv_data[0]), 32'(8'h11));
      chk("wrap_addr1", 32'(wv_addr[1]), 32'(0));
      chk("wrap_data1", 32'(wv_data[1]), 32'(8'h22));
    end
    host_read(4'd15, 8'h11, "wrap_reg15");
    host_read(4'd0,  8'h22, "wrap_reg0");

    // Burst read with master ACK across the wrap
    bus_start;
    put_byte(8'hA0, a0);
    put_byte(8'h0F, a1);
    bus_start;
    put_byte(8'hA1, a2);
    get_byte(rd0, 1'b0);
    get_byte(rd1, 1'b1);
    bus_stop;
    chk("rburst_acks", 32'({a0, a1, a2}), 32'(3'b000));
    chk("rburst_byte0", 32'(rd0), 32'(8'h11));
    chk("rburst_byte1", 32'(rd1), 32'(8'h22));

    // Abort after 4 data bits, then a normal write
    wv_addr.delete();
    bus_start;
    put_byte(8'hA0, a0);
    put_byte(8'h07, a1);
    for (int i = 7; i >= 4; i--) begin
      rd0 = 8'h12;
      put_bit(rd0[i]);
    end
    bus_stop;
    #40;
    chk("abort_wv", 32'(wv_addr.size()), 32'(0));
    chk("abort_sda", 32'(sda), 32'(1));
    host_read(4'd7, 8'hFF, "abort_reg7");
    wv_addr.delete();
    wv_data.delete();
    bus_start;
    put_byte(8'hA0, a0);
    put_byte(8'h07, a1);
    put_byte(8'h3C, a2);
    bus_stop;
    #40;
    chk("post_abort_acks", 32'({a0, a1, a2}), 32'(3'b000));
    chk("post_abort_wv", 32'(wv_addr.size()), 32'(1));
    host_read(4'd7, 8'h3C, "post_abort_reg7");

    // Reset while the target is driving read bit 7 (reg 8 is still zero)
    bus_start;
    put_byte(8'hA1, a0);
    chk("rst_rd_ack", 32'(a0), 32'(0));
    chk("rst_rd_busy", 32'(hif.busy), 32'(1));
    chk("rst_rd_driving", 32'(sda), 32'(0));
    reset = 1'b1;
    #1;
    chk("rst_rd_sda_release", 32'(sda), 32'(1));
    #9;
    chk("rst_rd_busy_clr", 32'(hif.busy), 32'(0));
    chk("rst_rd_wr_valid", 32'(hif.wr_valid), 32'(0));
    chk("rst_rd_wr_addr", 32'(hif.wr_addr), 32'(0));
    chk("rst_rd_wr_data", 32'(hif.wr_data), 32'(0));
    chk("rst_rd_host_rdata", 32'(hif.host_rdata), 32'(0));
    scl_m = 1'b1;
    sda_m = 1'b1;
    #20;
    reset = 1'b0;
    #Q;
    host_read(4'd7, 8'h00, "rst_rd_reg7_cleared");
    bus_start;
    put_byte(8'hA0, a0);
    put_byte(8'h05, a1);
    put_byte(8'hAB, a2);
    bus_stop;
    #40;
    chk("post_rst_acks", 32'({a0, a1, a2}), 32'(3'b000));
    host_read(4'd5, 8'hAB, "post_rst_reg5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
